midi_voice_alloc: RTL and testbench

- Upstream neighbour of the note-combining stage.
- Consumes raw MIDI bytes from the UART receiver and decodes note-on, note-off and all-notes-off messages, including running status.
- Maintains a 5-slot voice table and drives the burst interface that the combiner samples: per-slot on bits, per-slot {note, velocity} words and a one-cycle change strobe.

---
 rtl/midi_pkg.sv | 23 ++
 rtl/voice_slot_finder.sv | 44 ++++
 rtl/midi_voice_alloc.sv | 182 ++++++++++++++++++
 tb/tb_midi_voice_alloc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI voice allocator.
// Status nibbles, parser states and the per-slot voice word.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF      = 4'h8;
   localparam logic [3:0] NOTE_ON       = 4'h9;
   localparam logic [3:0] CTRL          = 4'hB;
   localparam logic [7:0] REALTIME_MIN  = 8'hF8;
   localparam logic [6:0] ALL_NOTES_OFF = 7'd123;

   typedef enum logic [1:0] {
      WAIT_STATUS,
      WAIT_D1,
      WAIT_D2,
      SKIP
   } parse_state_e;

   typedef struct packed {
      logic [7:0] note;
      logic [7:0] vel;
   } voice_word_t;

endpackage

// File: rtl/voice_slot_finder.sv
// Combinational slot search: note matches, lowest free slot and
// oldest slot (lowest index wins on equal age).
module voice_slot_finder
   import midi_pkg::*;
#(
   parameter int NUM_VOICES = 5,
   parameter int IW         = 3
) (
   input  voice_word_t           words_in [NUM_VOICES],
   input  logic [NUM_VOICES-1:0] on_in,
   input  logic [2:0]            ages_in [NUM_VOICES],
   input  logic [7:0]            note_in,
   output logic [NUM_VOICES-1:0] match_mask_out,
   output logic [IW-1:0]         first_free_idx_out,
   output logic                  any_free_out,
   output logic [IW-1:0]         oldest_idx_out
);

   logic [2:0] best_age;

   always_comb begin
      match_mask_out     = '0;
      first_free_idx_out = '0;
      any_free_out       = 1'b0;
      oldest_idx_out     = '0;
      best_age           = ages_in[0];
      for (int i = 0; i < NUM_VOICES; i++) begin
         match_mask_out[i] = on_in[i] && (words_in[i].note == note_in);
      end
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (!on_in[i]) begin
            any_free_out       = 1'b1;
            first_free_idx_out = IW'(i);
         end
      end
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (ages_in[i] > best_age) begin
            best_age       = ages_in[i];
            oldest_idx_out = IW'(i);
         end
      end
   end

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI byte parser with running status feeding a small voice table
// that the note combiner samples on each change strobe.
module midi_voice_alloc
   import midi_pkg::*;
#(
   parameter int NUM_VOICES = 5,
   parameter int CHANNEL    = 0,
   parameter bit OMNI       = 1'b1
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [7:0]                 byte_in,
   input  logic                       byte_valid_in,
   output logic [NUM_VOICES-1:0]      on_array_out,
   output logic [16*NUM_VOICES-1:0]   midi_burst_data_out,
   output logic                       midi_burst_change_out,
   output logic                       voices_full_out
);

   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   parse_state_e          state_q, state_d;
   logic [3:0]            stat_q, stat_d;
   logic [6:0]            d1_q, d1_d;
   logic [NUM_VOICES-1:0] on_q, on_d;
   voice_word_t           word_q [NUM_VOICES];
   voice_word_t           word_d [NUM_VOICES];
   logic [2:0]            age_q [NUM_VOICES];
   logic [2:0]            age_d [NUM_VOICES];
   logic                  chg_q, chg_d;
   logic                  full_q, full_d;

   logic [NUM_VOICES-1:0] match;
   logic [IW-1:0]         first_free, oldest, target;
   logic                  any_free;
   logic                  is_rt, is_sys, is_stat;
   logic                  ch_ok, known, commit;
   logic                  note_on, note_off, aof;
   logic [6:0]            d2;

   voice_slot_finder #(
      .NUM_VOICES (NUM_VOICES),
      .IW         (IW)
   ) u_finder (
      .words_in           (word_q),
      .on_in              (on_q),
      .ages_in            (age_q),
      .note_in            ({1'b0, d1_q}),
      .match_mask_out     (match),
      .first_free_idx_out (first_free),
      .any_free_out       (any_free),
      .oldest_idx_out     (oldest)
   );

   assign is_rt    = byte_in >= REALTIME_MIN;
   assign is_sys   = (byte_in[7:4] == 4'hF) && !is_rt;
   assign is_stat  = byte_in[7] && (byte_in[7:4] != 4'hF);
   assign ch_ok    = OMNI || (byte_in[3:0] == 4'(CHANNEL));
   assign known    = (byte_in[7:4] == NOTE_OFF) || (byte_in[7:4] == NOTE_ON) ||
                     (byte_in[7:4] == CTRL);
   assign d2       = byte_in[6:0];
   assign note_on  = (stat_q == NOTE_ON) && (d2 != 7'd0);
   assign note_off = (stat_q == NOTE_OFF) || ((stat_q == NOTE_ON) && (d2 == 7'd0));
   assign aof      = (stat_q == CTRL) && (d1_q == ALL_NOTES_OFF);
   assign target   = any_free ? first_free : oldest;

   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      d1_d    = d1_q;
      commit  = 1'b0;
      if (byte_valid_in) begin
         unique case (1'b1)
            is_rt: ;
            is_sys: begin
               stat_d  = 4'h0;
               state_d = SKIP;
            end
            is_stat: begin
               stat_d  = byte_in[7:4];
               state_d = (ch_ok && known) ? WAIT_D1 : SKIP;
            end
            default: begin
               unique case (state_q)
                  WAIT_D1: begin
                     d1_d    = byte_in[6:0];
                     state_d = WAIT_D2;
                  end
                  WAIT_D2: begin
                     commit  = 1'b1;
                     state_d = WAIT_D1;
                  end
                  WAIT_STATUS, SKIP: ;
               endcase
            end
         endcase
      end
   end

   always_comb begin
      on_d   = on_q;
      word_d = word_q;
      age_d  = age_q;
      chg_d  = 1'b0;
      if (commit) begin
         if (note_on && (|match)) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (match[i]) begin
                  word_d[i].vel = {1'b0, d2};
                  age_d[i]      = 3'd0;
               end
            end
            chg_d = 1'b1;
         end else if (note_on) begin
            // free slot or steal; every other sounding slot grows older
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (IW'(i) == target) begin
                  word_d[i] = '{note: {1'b0, d1_q}, vel: {1'b0, d2}};
                  on_d[i]   = 1'b1;
                  age_d[i]  = 3'd0;
               end else if (on_q[i] && (age_q[i] != 3'd7)) begin
                  age_d[i] = age_q[i] + 3'd1;
               end
            end
            chg_d = 1'b1;
         end else if (note_off) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (match[i]) begin
                  on_d[i]   = 1'b0;
                  word_d[i] = '0;
                  age_d[i]  = 3'd0;
               end
            end
            chg_d = |match;
         end else if (aof) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               word_d[i] = '0;
               age_d[i]  = 3'd0;
            end
            on_d  = '0;
            chg_d = |on_q;
         end
      end
      full_d = &on_d;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= WAIT_STATUS;
         stat_q  <= 4'h0;
         d1_q    <= 7'd0;
         on_q    <= '0;
         chg_q   <= 1'b0;
         full_q  <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            word_q[i] <= '0;
            age_q[i]  <= 3'd0;
         end
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
         d1_q    <= d1_d;
         on_q    <= on_d;
         chg_q   <= chg_d;
         full_q  <= full_d;
         word_q  <= word_d;
         age_q   <= age_d;
      end
   end

   always_comb begin
      midi_burst_data_out = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         midi_burst_data_out[16*i +: 16] = word_q[i];
      end
   end

   assign on_array_out          = on_q;
   assign midi_burst_change_out = chg_q;
   assign voices_full_out       = full_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: directed vector table, OMNI=0 check and
// randomized bytes against a slot-table model using allocation timestamps.
module tb_midi_voice_alloc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld;
   logic [7:0]  bin;
   logic [4:0]  on1, on2;
   logic [79:0] dat1, dat2;
   logic        chg1, chg2, full1, full2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   midi_voice_alloc #(.NUM_VOICES(5), .CHANNEL(0), .OMNI(1'b1)) dut (
      .clk_in                (clk),
      .rst_in                (rst_n),
      .byte_in               (bin),
      .byte_valid_in         (vld),
      .on_array_out          (on1),
      .midi_burst_data_out   (dat1),
      .midi_burst_change_out (chg1),
      .voices_full_out       (full1)
   );

   midi_voice_alloc #(.NUM_VOICES(5), .CHANNEL(0), .OMNI(1'b0)) dut_ch0 (
      .clk_in                (clk),
      .rst_in                (rst_n),
      .byte_in               (bin),
      .byte_valid_in         (vld),
      .on_array_out          (on2),
      .midi_burst_data_out   (dat2),
      .midi_burst_change_out (chg2),
      .voices_full_out       (full2)
   );

   typedef struct {
      bit          r;
      bit          v;
      logic [7:0]  b;
      logic [4:0]  on;
      bit          chg;
      int          slot;
      logic [15:0] word;
   } vec_t;

   vec_t vt[$];

   task automatic add(bit r, bit v, logic [7:0] b, logic [4:0] on, bit c,
                      int s, logic [15:0] w);
      vec_t x;
      x.r = r; x.v = v; x.b = b; x.on = on; x.chg = c; x.slot = s; x.word = w;
      vt.push_back(x);
   endtask

   task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(bit r, bit v, logic [7:0] b);
      @(negedge clk);
      rst_n = r;
      vld   = v;
      bin   = b;
      @(posedge clk);
      #1;
   endtask

   // reference model: slot contents plus allocation timestamps
   bit         m_ok;
   logic [3:0] m_hi;
   logic [6:0] pend[$];
   bit         m_on[5];
   logic [6:0] m_note[5];
   logic [6:0] m_vel[5];
   int         m_stamp[5];
   int         m_allocs;
   bit         m_chg;

   task automatic m_reset();
      m_ok = 0; m_hi = 0; pend.delete(); m_allocs = 0; m_chg = 0;
      for (int i = 0; i < 5; i++) begin
         m_on[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = 0;
      end
   endtask

   task automatic m_commit(logic [6:0] n, logic [6:0] v);
      int hit = -1;
      int tgt = -1;
      int best = -1;
      int age;
      bit any = 0;
      if (m_hi == 4'h9 && v != 0) begin
         for (int i = 0; i < 5; i++) if (m_on[i] && m_note[i] == n) hit = i;
         if (hit >= 0) begin
            m_vel[hit] = v;
            m_stamp[hit] = m_allocs;
         end else begin
            for (int i = 4; i >= 0; i--) if (!m_on[i]) tgt = i;
            if (tgt < 0) begin
               for (int i = 0; i < 5; i++) begin
                  age = m_allocs - m_stamp[i];
                  if (age > 7) age = 7;
                  if (age > best) begin best = age; tgt = i; end
               end
            end
            m_allocs++;
            m_on[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = v;
            m_stamp[tgt] = m_allocs;
         end
         m_chg = 1;
      end else if (m_hi == 4'h8 || m_hi == 4'h9) begin
         for (int i = 0; i < 5; i++)
            if (m_on[i] && m_note[i] == n) begin m_on[i] = 0; any = 1; end
         m_chg = any;
      end else if (m_hi == 4'hB && n == 7'd123) begin
         for (int i = 0; i < 5; i++) begin any |= m_on[i]; m_on[i] = 0; end
         m_chg = any;
      end
   endtask

   task automatic m_byte(logic [7:0] b);
      if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
         m_ok = 0; pend.delete();
      end else if (b[7]) begin
         m_hi = b[7:4];
         m_ok = (m_hi == 4'h8 || m_hi == 4'h9 || m_hi == 4'hB);
         pend.delete();
      end else if (m_ok) begin
         pend.push_back(b[6:0]);
         if (pend.size() == 2) begin
            m_commit(pend[0], pend[1]);
            pend.delete();
         end
      end
   endtask

   function automatic logic [7:0] rnd_byte();
      int r = $urandom_range(0, 99);
      int p;
      logic [7:0] st[10] = '{8'h90, 8'h90, 8'h90, 8'h80, 8'hB0,
                             8'h91, 8'hA0, 8'hC0, 8'hF0, 8'h9F};
      if (r < 10) return st[$urandom_range(0, 9)];
      if (r < 14) return 8'hF8 + 8'($urandom_range(0, 7));
      p = $urandom_range(0, 99);
      if (p < 10) return 8'h00;
      if (p < 16) return 8'h7B;
      return 8'h30 + 8'($urandom_range(0, 9));
   endfunction

   initial begin
      logic [79:0] exp;
      logic [4:0]  eon;
      bit          r;
      bit          v;
      logic [7:0]  b;

      rst_n = 1'b0; vld = 1'b0; bin = 8'h00;

      add(0, 0, 8'h00, 5'h00, 0, -1, 16'h0);
      add(0, 0, 8'h00, 5'h00, 0, 0, 16'h0);
      add(1, 1, 8'h90, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'h3C, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'h64, 5'h01, 1, 0, 16'h3C64);
      add(1, 0, 8'h00, 5'h01, 0, 0, 16'h3C64);
      add(1, 1, 8'h40, 5'h01, 0, -1, 16'h0);
      add(1, 1, 8'h50, 5'h03, 1, 1, 16'h4050);
      add(1, 0, 8'h00, 5'h03, 0, 1, 16'h4050);
      add(1, 1, 8'h3C, 5'h03, 0, -1, 16'h0);
      add(1, 1, 8'h00, 5'h02, 1, 0, 16'h0000);
      add(1, 0, 8'h00, 5'h02, 0, 1, 16'h4050);
      add(0, 0, 8'h00, 5'h00, 0, 1, 16'h0000);
      add(1, 1, 8'h90, 5'h00, 0, -1, 16'h0);
      eon = 5'h00;
      for (int k = 0; k < 6; k++) begin
         add(1, 1, 8'h30 + 8'(k), eon, 0, -1, 16'h0);
         eon = (k < 5) ? 5'((1 << (k + 1)) - 1) : 5'h1F;
         add(1, 1, 8'h40, eon, 1, (k < 5) ? k : 0, {8'h30 + 8'(k), 8'h40});
      end
      add(1, 0, 8'h00, 5'h1F, 0, 0, 16'h3540);
      add(1, 1, 8'h31, 5'h1F, 0, -1, 16'h0);
      add(1, 1, 8'h7F, 5'h1F, 1, 1, 16'h317F);
      add(1, 0, 8'h00, 5'h1F, 0, 2, 16'h3240);
      add(1, 1, 8'h80, 5'h1F, 0, -1, 16'h0);
      add(1, 1, 8'h50, 5'h1F, 0, -1, 16'h0);
      add(1, 1, 8'h00, 5'h1F, 0, 0, 16'h3540);
      add(1, 0, 8'h00, 5'h1F, 0, 1, 16'h317F);
      add(1, 1, 8'hB0, 5'h1F, 0, -1, 16'h0);
      add(1, 1, 8'h7B, 5'h1F, 0, -1, 16'h0);
      add(1, 1, 8'h00, 5'h00, 1, 4, 16'h0000);
      add(1, 0, 8'h00, 5'h00, 0, 0, 16'h0000);
      add(1, 1, 8'h90, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'hF8, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'h3C, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'hFE, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'h64, 5'h01, 1, 0, 16'h3C64);
      add(1, 0, 8'h00, 5'h01, 0, 0, 16'h3C64);
      add(0, 0, 8'h00, 5'h00, 0, 0, 16'h0000);
      add(1, 1, 8'h90, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'h3C, 5'h00, 0, -1, 16'h0);
      add(0, 0, 8'h00, 5'h00, 0, 0, 16'h0000);
      add(1, 1, 8'h64, 5'h00, 0, 0, 16'h0000);
      add(1, 0, 8'h00, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'h3C, 5'h00, 0, -1, 16'h0);
      add(1, 1, 8'h64, 5'h00, 0, 0, 16'h0000);

      foreach (vt[i]) begin
         apply(vt[i].r, vt[i].v, vt[i].b);
         chk($sformatf("vec%0d_on", i), 80'(on1), 80'(vt[i].on));
         chk($sformatf("vec%0d_chg", i), 80'(chg1), 80'(vt[i].chg));
         chk($sformatf("vec%0d_full", i), 80'(full1), 80'(vt[i].on == 5'h1F));
         if (vt[i].slot >= 0)
            chk($sformatf("vec%0d_slot%0d", i, vt[i].slot),
                80'(dat1[vt[i].slot*16 +: 16]), 80'(vt[i].word));
      end

      // channel filter: OMNI=0, CHANNEL=0
      apply(0, 0, 8'h00);
      apply(1, 1, 8'h91);
      apply(1, 1, 8'h3C);
      apply(1, 1, 8'h64);
      chk("ch1_chg", 80'(chg2), 80'(0));
      chk("ch1_on", 80'(on2), 80'(0));
      apply(1, 0, 8'h00);
      chk("ch1_chg_late", 80'(chg2), 80'(0));
      apply(1, 1, 8'h90);
      apply(1, 1, 8'h3C);
      apply(1, 1, 8'h64);
      chk("ch0_chg", 80'(chg2), 80'(1));
      chk("ch0_on", 80'(on2), 80'(1));
      chk("ch0_slot0", 80'(dat2[15:0]), 80'(16'h3C64));

      // randomized run against the model
      m_reset();
      for (int c = 0; c < 4000; c++) begin
         r = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
         v = ($urandom_range(0, 9) < 6);
         b = rnd_byte();
         @(negedge clk);
         rst_n = r; vld = v; bin = b;
         @(posedge clk);
         m_chg = 0;
         if (!r) m_reset();
         else if (v) m_byte(b);
         #1;
         exp = '0;
         eon = '0;
         for (int i = 0; i < 5; i++) begin
            eon[i] = m_on[i];
            if (m_on[i]) exp[i*16 +: 16] = {1'b0, m_note[i], 1'b0, m_vel[i]};
         end
         chk($sformatf("rnd%0d_on", c), 80'(on1), 80'(eon));
         chk($sformatf("rnd%0d_chg", c), 80'(chg1), 80'(m_chg));
         chk($sformatf("rnd%0d_full", c), 80'(full1), 80'(eon == 5'h1F));
         chk($sformatf("rnd%0d_data", c), dat1, exp);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
